// File: rtl/aes_pkg.sv
// Shared AES constants and the S-box lookup tag used by shared-ROM arbiters.
package aes_pkg;

   localparam int unsigned SBOX_AW = 8;
   localparam int unsigned SBOX_DW = 8;

   localparam int unsigned REQ_SUBBYTES = 0;
   localparam int unsigned REQ_KEYEXP   = 1;

   // Index field sized for the largest supported requester count (8).
   localparam int unsigned TAG_IDX_W = 3;

   typedef struct packed {
      logic                 valid;
      logic [TAG_IDX_W-1:0] idx;
   } sbox_tag_t;

   function automatic int unsigned tag_width(input int unsigned num_req);
      return 1 + $clog2(num_req);
   endfunction

endpackage

// File: rtl/sbox_rr_pick.sv
// Rotate-priority picker: first asserted valid bit at or after ptr, wrapping to 0.
module sbox_rr_pick #(
   parameter int unsigned NUM = 4,
   parameter int unsigned IW  = $clog2(NUM)
) (
   input  logic [NUM-1:0] valid,
   input  logic [IW-1:0]  ptr,
   output logic [NUM-1:0] grant,
   output logic [IW-1:0]  idx,
   output logic           any
);

   always_comb begin
      int unsigned pos;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = 0;
      for (int k = 0; k < NUM; k++) begin
         pos = (int'(ptr) + k) % NUM;
         if (!any && valid[pos]) begin
            grant[pos] = 1'b1;
            idx        = IW'(pos);
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sbox_share_arb.sv
// Round-robin arbiter sharing one synchronous-read S-box ROM between byte-serial
// requesters, with bounded lock bursts and in-order tagged response routing.
module sbox_share_arb
   import aes_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ROM_LAT  = 1,
   parameter int unsigned MAX_LOCK = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [SBOX_AW*NUM_REQ-1:0] req_addr,
   input  logic [NUM_REQ-1:0]         req_lock,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [SBOX_DW-1:0]         rsp_data,
   output logic                       rom_en,
   output logic [SBOX_AW-1:0]         rom_addr,
   input  logic [SBOX_DW-1:0]         rom_dout
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned CW = 4;

   logic [IW-1:0]      ptr_q, ptr_d;
   logic [CW-1:0]      lock_cnt_q, lock_cnt_d, eff_cnt;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic               xfer;
   sbox_tag_t          tag_q [ROM_LAT];
   sbox_tag_t          tag_out;

   sbox_rr_pick #(
      .NUM (NUM_REQ),
      .IW  (IW)
   ) u_pick (
      .valid (req_valid),
      .ptr   (ptr_q),
      .grant (pick_gnt),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      xfer       = pick_any & ~rst;
      // A grant to anyone other than the current lock holder starts a fresh count.
      eff_cnt    = (pick_idx == ptr_q) ? lock_cnt_q : '0;
      ptr_d      = ptr_q;
      lock_cnt_d = lock_cnt_q;
      if (xfer) begin
         if (req_lock[pick_idx] && ((32'(eff_cnt) + 32'd1) < MAX_LOCK)) begin
            ptr_d      = pick_idx;
            lock_cnt_d = eff_cnt + 1'b1;
         end else begin
            ptr_d      = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            lock_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         lock_cnt_q <= '0;
         for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_cnt_q <= lock_cnt_d;
         tag_q[0]   <= '{valid: xfer, idx: TAG_IDX_W'(pick_idx)};
         for (int i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   always_comb begin
      req_ready = rst ? '0 : pick_gnt;
      rom_en    = xfer;
      rom_addr  = xfer ? req_addr[{pick_idx, 3'b000} +: SBOX_AW] : '0;
   end

   // Gating with rst drops a result that would otherwise emerge in the reset cycle.
   always_comb begin
      tag_out   = tag_q[ROM_LAT-1];
      rsp_valid = '0;
      rsp_data  = rom_dout;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (tag_out.valid && !rst && (tag_out.idx == TAG_IDX_W'(i))) rsp_valid[i] = 1'b1;
      end
   end

endmodule

// File: tb/tb_sbox_share_arb.sv
// Table-driven bench for sbox_share_arb with an AES S-box ROM model and a response
// scoreboard; a second instance with ROM_LAT = 2 covers reset during a lookup.
module tb_sbox_share_arb;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic [3:0]  lk;
      logic [31:0] addr;
      logic [3:0]  gnt;
   } vec_t;

   typedef struct {
      int unsigned idx;
      logic [7:0]  data;
      int unsigned due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_addr = '0;
   logic [3:0]  req_lock = '0;

   logic [3:0]  req_ready1, rsp_valid1, req_ready2, rsp_valid2;
   logic [7:0]  rsp_data1, rom_addr1, rom_dout1, rsp_data2, rom_addr2, rom_dout2, rom_p2;
   logic        rom_en1, rom_en2;

   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned cyc = 0;
   exp_t        sbq[$];
   vec_t        tbl[$];

   always #5 clk = ~clk;

   sbox_share_arb #(.NUM_REQ(4), .ROM_LAT(1), .MAX_LOCK(4)) dut1 (
      .clk (clk), .rst (rst), .req_valid (req_valid), .req_addr (req_addr),
      .req_lock (req_lock), .req_ready (req_ready1), .rsp_valid (rsp_valid1),
      .rsp_data (rsp_data1), .rom_en (rom_en1), .rom_addr (rom_addr1), .rom_dout (rom_dout1)
   );

   sbox_share_arb #(.NUM_REQ(4), .ROM_LAT(2), .MAX_LOCK(4)) dut2 (
      .clk (clk), .rst (rst), .req_valid (req_valid), .req_addr (req_addr),
      .req_lock (req_lock), .req_ready (req_ready2), .rsp_valid (rsp_valid2),
      .rsp_data (rsp_data2), .rom_en (rom_en2), .rom_addr (rom_addr2), .rom_dout (rom_dout2)
   );

   always_ff @(posedge clk) begin
      if (rom_en1) rom_dout1 <= SBOX[rom_addr1];
      if (rom_en2) rom_p2 <= SBOX[rom_addr2];
      rom_dout2 <= rom_p2;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle, then check dut1 mid-cycle against the vector and the scoreboard.
   task automatic step(input vec_t t);
      exp_t        e;
      logic [3:0]  exp_rsp;
      logic [7:0]  exp_addr;
      int unsigned g;
      @(posedge clk);
      #1;
      cyc++;
      rst       = t.rst;
      req_valid = t.v;
      req_lock  = t.lk;
      req_addr  = t.addr;
      if (t.rst) sbq.delete();
      #4;
      exp_rsp = '0;
      if (sbq.size() != 0 && sbq[0].due == cyc) exp_rsp = 4'(1 << sbq[0].idx);
      chk("rsp_valid", {28'b0, rsp_valid1}, {28'b0, exp_rsp});
      if (exp_rsp != '0) begin
         e = sbq.pop_front();
         chk("rsp_data", {24'b0, rsp_data1}, {24'b0, e.data});
      end
      g = 0;
      for (int i = 0; i < 4; i++) if (t.gnt[i]) g = i;
      exp_addr = (t.gnt != '0) ? t.addr[8*g +: 8] : 8'h00;
      chk("req_ready", {28'b0, req_ready1}, {28'b0, t.gnt});
      chk("rom_en", {31'b0, rom_en1}, {31'b0, |t.gnt});
      chk("rom_addr", {24'b0, rom_addr1}, {24'b0, exp_addr});
      if (t.gnt != '0) sbq.push_back('{idx: g, data: SBOX[exp_addr], due: cyc + 1});
   endtask

   initial begin
      // Single requester back-to-back: 0x00 -> 0x63, 0x53 -> 0xED.
      tbl.push_back('{1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'h00000000, 4'b0001});
      tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'h00000053, 4'b0001});
      tbl.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000});
      // All valid, no lock; reset also suppresses a valid request.
      tbl.push_back('{1'b1, 4'b1111, 4'b0000, 32'h44332211, 4'b0000});
      tbl.push_back('{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0001});
      tbl.push_back('{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0010});
      tbl.push_back('{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0100});
      tbl.push_back('{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b1000});
      tbl.push_back('{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0001});
      tbl.push_back('{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0010});
      // Lock burst bounded by MAX_LOCK: 1,1,1,1,0,1 once ptr sits at 1.
      tbl.push_back('{1'b1, 4'b1111, 4'b0000, 32'h0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'h0000c0a0, 4'b0001});
      for (int i = 0; i < 4; i++)
         tbl.push_back('{1'b0, 4'b0011, 4'b0010, 32'h0000c0a0, 4'b0010});
      tbl.push_back('{1'b0, 4'b0011, 4'b0010, 32'h0000c0a0, 4'b0001});
      tbl.push_back('{1'b0, 4'b0011, 4'b0010, 32'h0000c0a0, 4'b0010});
      // Wrap-around from ptr = 3.
      tbl.push_back('{1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0100, 4'b0000, 32'hff7e0000, 4'b0100});
      tbl.push_back('{1'b0, 4'b1001, 4'b0000, 32'hff7e0012, 4'b1000});
      tbl.push_back('{1'b0, 4'b1001, 4'b0000, 32'hff7e0012, 4'b0001});
      tbl.push_back('{1'b0, 4'b1001, 4'b0000, 32'hff7e0012, 4'b1000});
      // Early unlock: 2 locked twice, then unlocked, then 3.
      tbl.push_back('{1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000});
      tbl.push_back('{1'b0, 4'b0010, 4'b0000, 32'h00003300, 4'b0010});
      tbl.push_back('{1'b0, 4'b1100, 4'b0100, 32'h9a5b0000, 4'b0100});
      tbl.push_back('{1'b0, 4'b1100, 4'b0100, 32'h9a5c0000, 4'b0100});
      tbl.push_back('{1'b0, 4'b1100, 4'b0000, 32'h9a5d0000, 4'b0100});
      tbl.push_back('{1'b0, 4'b1100, 4'b0000, 32'h9a5d0000, 4'b1000});
      tbl.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000});

      foreach (tbl[i]) step(tbl[i]);

      // ROM_LAT = 2: reset the cycle after a transfer discards the lookup.
      step('{1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000});
      step('{1'b0, 4'b0010, 4'b0000, 32'h0000ab00, 4'b0010});
      chk("lat2_ready_xfer", {28'b0, req_ready2}, 32'h2);
      step('{1'b1, 4'b0010, 4'b0000, 32'h0000ab00, 4'b0000});
      chk("lat2_ready_in_rst", {28'b0, req_ready2}, 32'h0);
      chk("lat2_rom_en_in_rst", {31'b0, rom_en2}, 32'h0);
      chk("lat2_rom_addr_in_rst", {24'b0, rom_addr2}, 32'h0);
      step('{1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000});
      chk("lat2_rsp_after_rst", {28'b0, rsp_valid2}, 32'h0);
      step('{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0001});
      chk("lat2_ptr_reset", {28'b0, req_ready2}, 32'h1);
      step('{1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000});
      chk("lat2_rsp_early", {28'b0, rsp_valid2}, 32'h0);
      step('{1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000});
      chk("lat2_rsp_valid", {28'b0, rsp_valid2}, 32'h1);
      chk("lat2_rsp_data", {24'b0, rsp_data2}, 32'h82);
      step('{1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000});
      chk("lat2_rsp_pulse", {28'b0, rsp_valid2}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
